// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM states, parity modes, oversampling rate
// and the per-byte result payload.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned PAR_NONE   = 0;
  localparam int unsigned PAR_EVEN   = 1;
  localparam int unsigned PAR_ODD    = 2;
  localparam int unsigned STATE_W    = 3;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned BIT_W      = 3;
  localparam int unsigned BYTE_W     = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              frame_err;
    logic              parity_err;
  } rx_result_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: 16x oversampled start/data/parity/stop recovery with a
// one-clk byte strobe and per-byte framing and parity flags.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned PARITY  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              s_tick,
  output logic [BYTE_W-1:0] dout,
  output logic              rx_done_tick,
  output logic              frame_err,
  output logic              parity_err
);

  localparam logic [CNT_W-1:0] S_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] S_BIT  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] S_STOP = CNT_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0] N_LAST = BIT_W'(DBIT - 1);

  logic rx_s;
  logic rx_d;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  s, s_nxt;
  logic [BIT_W-1:0]  n, n_nxt;
  logic [BYTE_W-1:0] b, b_nxt;
  logic              par_bad, par_bad_nxt;
  rx_result_t        res, res_nxt;
  logic              done, done_nxt;
  logic [1:0]        settle, settle_nxt;
  logic              armed, armed_nxt;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_d    <= 1'b1;
      state   <= IDLE;
      s       <= '0;
      n       <= '0;
      b       <= '0;
      par_bad <= 1'b0;
      res     <= '0;
      done    <= 1'b0;
      settle  <= '0;
      armed   <= 1'b0;
    end else begin
      rx_d    <= rx_s;
      state   <= state_nxt;
      s       <= s_nxt;
      n       <= n_nxt;
      b       <= b_nxt;
      par_bad <= par_bad_nxt;
      res     <= res_nxt;
      done    <= done_nxt;
      settle  <= settle_nxt;
      armed   <= armed_nxt;
    end
  end

  // A start edge needs a genuinely observed high line first, so a line still
  // low when reset releases is not mistaken for the synchronizer's reset 1->0.
  always_comb begin
    state_nxt   = state;
    s_nxt       = s;
    n_nxt       = n;
    b_nxt       = b;
    par_bad_nxt = par_bad;
    res_nxt     = res;
    done_nxt    = 1'b0;
    settle_nxt  = {settle[0], 1'b1};
    armed_nxt   = armed | (settle[1] & rx_s);

    unique case (state)
      IDLE: begin
        if (armed && rx_d && !rx_s) begin
          state_nxt = START;
          s_nxt     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_MID) begin
            if (!rx_s) begin
              state_nxt   = DATA;
              s_nxt       = '0;
              n_nxt       = '0;
              par_bad_nxt = 1'b0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            s_nxt = s + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            s_nxt             = '0;
            b_nxt             = {1'b0, b[BYTE_W-1:1]};
            b_nxt[DBIT-1]     = rx_s;
            if (n == N_LAST) begin
              state_nxt = (PARITY != PAR_NONE) ? PAR : STOP;
            end else begin
              n_nxt = n + BIT_W'(1);
            end
          end else begin
            s_nxt = s + CNT_W'(1);
          end
        end
      end
      PAR: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            par_bad_nxt = ((^b[DBIT-1:0]) ^ rx_s) != (PARITY == PAR_ODD);
            state_nxt   = STOP;
            s_nxt       = '0;
          end else begin
            s_nxt = s + CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP) begin
            done_nxt           = 1'b1;
            res_nxt.data       = b;
            res_nxt.frame_err  = ~rx_s;
            res_nxt.parity_err = par_bad;
            state_nxt          = IDLE;
          end else begin
            s_nxt = s + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dout         = res.data;
  assign frame_err    = res.frame_err;
  assign parity_err   = res.parity_err;
  assign rx_done_tick = done;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: five configurations share clk, reset
// and s_tick; a frame-level scoreboard checks strobes, timing and held outputs.
module tb_uart_rx_frame;

  localparam int NI = 5;
  localparam int DB [NI] = '{8, 8, 8, 7, 8};
  localparam int PR [NI] = '{0, 1, 2, 0, 0};
  localparam int SB [NI] = '{16, 16, 16, 16, 32};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx_a   [NI];
  logic [7:0] dout_a [NI];
  logic       done_a [NI];
  logic       fe_a   [NI];
  logic       pe_a   [NI];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   tick_per = 4;
  logic tick_en = 1'b1;
  int   tick_div = 0;
  int   tick_cnt = 0;

  logic [9:0] exp_q [NI][$];
  int         st_q  [NI][$];
  logic [9:0] hold  [NI];
  logic       prev_done [NI];

  always #5 clk = ~clk;

  uart_rx_frame #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u0 (
    .clk(clk), .reset(reset), .rx(rx_a[0]), .s_tick(s_tick), .dout(dout_a[0]),
    .rx_done_tick(done_a[0]), .frame_err(fe_a[0]), .parity_err(pe_a[0]));
  uart_rx_frame #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u1 (
    .clk(clk), .reset(reset), .rx(rx_a[1]), .s_tick(s_tick), .dout(dout_a[1]),
    .rx_done_tick(done_a[1]), .frame_err(fe_a[1]), .parity_err(pe_a[1]));
  uart_rx_frame #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u2 (
    .clk(clk), .reset(reset), .rx(rx_a[2]), .s_tick(s_tick), .dout(dout_a[2]),
    .rx_done_tick(done_a[2]), .frame_err(fe_a[2]), .parity_err(pe_a[2]));
  uart_rx_frame #(.DBIT(7), .SB_TICK(16), .PARITY(0)) u3 (
    .clk(clk), .reset(reset), .rx(rx_a[3]), .s_tick(s_tick), .dout(dout_a[3]),
    .rx_done_tick(done_a[3]), .frame_err(fe_a[3]), .parity_err(pe_a[3]));
  uart_rx_frame #(.DBIT(8), .SB_TICK(32), .PARITY(0)) u4 (
    .clk(clk), .reset(reset), .rx(rx_a[4]), .s_tick(s_tick), .dout(dout_a[4]),
    .rx_done_tick(done_a[4]), .frame_err(fe_a[4]), .parity_err(pe_a[4]));

  // Baud tick generator with adjustable period and a freeze control
  always @(posedge clk) begin
    if (tick_en && tick_div >= tick_per - 1) begin
      s_tick   <= 1'b1;
      tick_div <= 0;
    end else begin
      s_tick <= 1'b0;
      if (tick_en) tick_div <= tick_div + 1;
    end
    if (s_tick) tick_cnt <= tick_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
    #1;
  endtask

  // Drive one frame on line i and record what the receiver must report for it
  task automatic send_frame(input int i, input logic [7:0] data, input logic par_bit,
                            input logic stop_val, input bit pause);
    int         nb;
    logic [7:0] m;
    logic       corr;
    nb   = DB[i];
    m    = data & 8'((1 << nb) - 1);
    corr = (^m) ^ (PR[i] == 2);
    exp_q[i].push_back({m, ~stop_val, (PR[i] != 0) && (par_bit != corr)});
    st_q[i].push_back(tick_cnt);
    rx_a[i] = 1'b0;
    wait_ticks(16);
    for (int k = 0; k < nb; k++) begin
      rx_a[i] = data[k];
      wait_ticks(16);
      if (pause && k == 3) begin
        tick_en = 1'b0;
        repeat (60) @(posedge clk);
        #1 tick_en = 1'b1;
      end
    end
    if (PR[i] != 0) begin
      rx_a[i] = par_bit;
      wait_ticks(16);
    end
    rx_a[i] = stop_val;
    wait_ticks(SB[i]);
    rx_a[i] = 1'b1;
  endtask

  // Scoreboard: strobe legality, strobe timing, and held outputs every cycle
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        hold[i] = '0;
        exp_q[i].delete();
        st_q[i].delete();
        prev_done[i] = 1'b0;
      end else begin
        if (done_a[i]) begin
          chk($sformatf("strobe_width_u%0d", i), 32'(prev_done[i]), 32'd0);
          chk($sformatf("strobe_expected_u%0d", i), 32'(exp_q[i].size() != 0), 32'd1);
          if (exp_q[i].size() != 0) begin
            int t0, dly, nom;
            hold[i] = exp_q[i].pop_front();
            t0  = st_q[i].pop_front();
            dly = tick_cnt - t0;
            nom = 8 + 16 * (DB[i] + ((PR[i] != 0) ? 1 : 0)) + SB[i];
            chk($sformatf("strobe_timing_u%0d(dly=%0d,nom=%0d)", i, dly, nom),
                32'(dly >= nom && dly <= nom + 4), 32'd1);
          end
        end
        prev_done[i] = done_a[i];
      end
      chk($sformatf("outputs_u%0d", i), 32'({dout_a[i], fe_a[i], pe_a[i]}), 32'(hold[i]));
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) rx_a[i] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_dout", 32'(dout_a[0]), 32'h00);
    chk("reset_done", 32'(done_a[0]), 32'd0);
    chk("reset_fe", 32'(fe_a[0]), 32'd0);
    chk("reset_pe", 32'(pe_a[0]), 32'd0);
    reset = 1'b0;
    wait_ticks(10);

    // Basic 8N1 byte
    send_frame(0, 8'h41, 1'b0, 1'b1, 0);
    wait_ticks(4);
    chk("basic_dout", 32'(dout_a[0]), 32'h41);
    chk("basic_fe", 32'(fe_a[0]), 32'd0);

    // Even parity, good then bad parity bit; odd parity good
    send_frame(1, 8'hA5, 1'b0, 1'b1, 0);
    wait_ticks(4);
    chk("even_ok_pe", 32'(pe_a[1]), 32'd0);
    send_frame(1, 8'hA5, 1'b1, 1'b1, 0);
    wait_ticks(4);
    chk("even_bad_dout", 32'(dout_a[1]), 32'hA5);
    chk("even_bad_pe", 32'(pe_a[1]), 32'd1);
    send_frame(2, 8'hA5, 1'b1, 1'b1, 0);
    wait_ticks(4);
    chk("odd_ok_pe", 32'(pe_a[2]), 32'd0);

    // Framing error followed by a clean frame
    send_frame(0, 8'h3C, 1'b0, 1'b0, 0);
    wait_ticks(4);
    chk("ferr_dout", 32'(dout_a[0]), 32'h3C);
    chk("ferr_fe", 32'(fe_a[0]), 32'd1);
    wait_ticks(20);
    send_frame(0, 8'h00, 1'b0, 1'b1, 0);
    wait_ticks(4);
    chk("ferr_clear_fe", 32'(fe_a[0]), 32'd0);

    // Glitch shorter than half a bit, then a real frame
    rx_a[0] = 1'b0;
    wait_ticks(5);
    rx_a[0] = 1'b1;
    wait_ticks(30);
    chk("glitch_dout_held", 32'(dout_a[0]), 32'h00);
    send_frame(0, 8'h7E, 1'b0, 1'b1, 0);
    wait_ticks(4);
    chk("after_glitch_dout", 32'(dout_a[0]), 32'h7E);

    // s_tick absent for a while mid-frame
    send_frame(0, 8'h96, 1'b0, 1'b1, 1);
    wait_ticks(4);
    chk("frozen_dout", 32'(dout_a[0]), 32'h96);

    // s_tick every clk
    tick_per = 1;
    wait_ticks(4);
    send_frame(0, 8'hC3, 1'b0, 1'b1, 0);
    wait_ticks(8);
    chk("fast_tick_dout", 32'(dout_a[0]), 32'hC3);
    tick_per = 4;
    wait_ticks(4);

    // 7-bit frames back to back
    send_frame(3, 8'h55, 1'b0, 1'b1, 0);
    send_frame(3, 8'h2A, 1'b0, 1'b1, 0);
    wait_ticks(4);
    chk("b2b_dout", 32'(dout_a[3]), 32'h2A);
    chk("b2b_bit7", 32'(dout_a[3][7]), 32'd0);

    // Two stop bits, back to back
    send_frame(4, 8'h81, 1'b0, 1'b1, 0);
    send_frame(4, 8'h5A, 1'b0, 1'b1, 0);
    wait_ticks(4);
    chk("sb32_dout", 32'(dout_a[4]), 32'h5A);

    // Reset during data bit 3 of 0xFF, released with the line still low
    rx_a[0] = 1'b0;
    wait_ticks(16);
    for (int k = 0; k < 3; k++) begin
      rx_a[0] = 1'b1;
      wait_ticks(16);
    end
    wait_ticks(8);
    rx_a[0] = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wait_ticks(40);
    chk("abort_dout", 32'(dout_a[0]), 32'h00);
    chk("abort_fe", 32'(fe_a[0]), 32'd0);
    rx_a[0] = 1'b1;
    wait_ticks(20);
    send_frame(0, 8'h12, 1'b0, 1'b1, 0);
    wait_ticks(4);
    chk("post_abort_dout", 32'(dout_a[0]), 32'h12);

    wait_ticks(40);
    for (int i = 0; i < NI; i++)
      chk($sformatf("pending_frames_u%0d", i), 32'(exp_q[i].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
